slave_port: RTL and testbench

- Slave-side endpoint of the serial system bus.
- Deserialises the address, burst count and write-data bit streams driven by a master port, then issues parallel write/read strobes to a local memory.
- For reads, serialises the returned data back to the master.
- Sits between the bus interconnect/slave-select decoder and one slave memory.

---
 rtl/bus_pkg.sv | 22 ++
 rtl/serial_shifter.sv | 26 ++
 rtl/slave_port.sv | 169 ++++++++++++++++
 tb/tb_slave_port.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared serial-bus definitions: default field widths and port state encodings,
// so that master and slave ports agree on both.
package bus_pkg;

  localparam int ADDR_W_DEF  = 12;
  localparam int DATA_W_DEF  = 8;
  localparam int BURST_W_DEF = 13;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RX_HDR  = 3'd1,
    ST_RX_DATA = 3'd2,
    ST_MEM_WR  = 3'd3,
    ST_MEM_RD  = 3'd4,
    ST_TX_DATA = 3'd5
  } bus_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/serial_shifter.sv
// LSB-first serial shifter: shift-in enters at the MSB and moves toward bit 0,
// shift-out is bit 0. Parallel load takes priority over shifting; with neither
// enable set the contents hold.
module serial_shifter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_en,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic             sout
);

  // load, shift right, or hold
  always_ff @(posedge clk) begin
    if (reset)         q <= '0;
    else if (load_en)  q <= load_data;
    else if (shift_en) q <= {sin, q[WIDTH-1:1]};
  end

  assign sout = q[0];

endmodule

// File: rtl/slave_port.sv
// Serial-bus slave endpoint: deserialises header and write data, issues
// memory strobes, and serialises read data back to the master.
module slave_port
  import bus_pkg::*;
#(
  parameter int ADDR_WIDTH  = ADDR_W_DEF,
  parameter int DATA_WIDTH  = DATA_W_DEF,
  parameter int BURST_WIDTH = BURST_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  slave_select,
  input  logic                  master_valid,
  input  logic                  write_en,
  input  logic                  read_en,
  input  logic                  rx_address,
  input  logic                  rx_burst_number,
  input  logic                  rx_data,
  input  logic                  master_ready,
  output logic                  slave_ready,
  output logic                  slave_valid,
  output logic                  tx_data,
  output logic                  slave_tx_done,
  output logic                  rx_done,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_write,
  output logic                  mem_read,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_rvalid
);

  localparam int HDR_LEN = max_int(ADDR_WIDTH, BURST_WIDTH);
  localparam int CNT_W   = $clog2(max_int(HDR_LEN, DATA_WIDTH) + 1);

  bus_state_e state, nxt_state;

  logic [CNT_W-1:0]       cnt;       // bit index within header / data byte / tx byte
  logic [BURST_WIDTH-1:0] beat;
  logic                   is_read;
  logic                   rd_wait;   // MEM_RD: strobe issued, waiting for mem_rvalid
  logic                   tx_done_q;

  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [BURST_WIDTH-1:0] burst_q;
  logic [DATA_WIDTH-1:0]  wdata_q;
  logic [DATA_WIDTH-1:0]  tx_par_unused;
  logic                   addr_sout_unused, burst_sout_unused, wdata_sout_unused;
  logic                   tx_bit;

  logic accept, start, abort, hdr_last, data_last, tx_xfer, tx_last, last_beat;

  assign accept    = slave_ready && master_valid;
  assign start     = (state == ST_IDLE) && slave_select && master_valid && (write_en ^ read_en);
  assign abort     = (state != ST_IDLE) && !slave_select;
  assign hdr_last  = (state == ST_RX_HDR) && accept && (cnt == CNT_W'(HDR_LEN - 1));
  assign data_last = (state == ST_RX_DATA) && accept && (cnt == CNT_W'(DATA_WIDTH - 1));
  assign tx_xfer   = (state == ST_TX_DATA) && master_ready;
  assign tx_last   = tx_xfer && (cnt == CNT_W'(DATA_WIDTH - 1));
  assign last_beat = (beat == burst_q);

  // header fields: bit 0 arrives on the start cycle, surplus bits of the
  // shorter field are simply not shifted in
  serial_shifter #(.WIDTH(ADDR_WIDTH)) u_addr (
    .clk(clk), .reset(reset), .load_en(1'b0), .load_data('0),
    .shift_en(start || ((state == ST_RX_HDR) && accept && (int'(cnt) < ADDR_WIDTH))),
    .sin(rx_address), .q(addr_q), .sout(addr_sout_unused)
  );

  serial_shifter #(.WIDTH(BURST_WIDTH)) u_burst (
    .clk(clk), .reset(reset), .load_en(1'b0), .load_data('0),
    .shift_en(start || ((state == ST_RX_HDR) && accept && (int'(cnt) < BURST_WIDTH))),
    .sin(rx_burst_number), .q(burst_q), .sout(burst_sout_unused)
  );

  serial_shifter #(.WIDTH(DATA_WIDTH)) u_wdata (
    .clk(clk), .reset(reset), .load_en(1'b0), .load_data('0),
    .shift_en((state == ST_RX_DATA) && accept),
    .sin(rx_data), .q(wdata_q), .sout(wdata_sout_unused)
  );

  serial_shifter #(.WIDTH(DATA_WIDTH)) u_tx (
    .clk(clk), .reset(reset),
    .load_en((state == ST_MEM_RD) && rd_wait && mem_rvalid && !abort),
    .load_data(mem_rdata),
    .shift_en(tx_xfer), .sin(1'b0), .q(tx_par_unused), .sout(tx_bit)
  );

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= nxt_state;
  end

  // next-state logic; abort on slave_select loss overrides every transition
  always_comb begin
    nxt_state = state;
    if (abort) begin
      nxt_state = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:    if (start) nxt_state = ST_RX_HDR;
        ST_RX_HDR:  if (hdr_last) nxt_state = is_read ? ST_MEM_RD : ST_RX_DATA;
        ST_RX_DATA: if (data_last) nxt_state = ST_MEM_WR;
        ST_MEM_WR:  nxt_state = last_beat ? ST_IDLE : ST_RX_DATA;
        ST_MEM_RD:  if (rd_wait && mem_rvalid) nxt_state = ST_TX_DATA;
        ST_TX_DATA: if (tx_last) nxt_state = last_beat ? ST_IDLE : ST_MEM_RD;
        default:    nxt_state = ST_IDLE;
      endcase
    end
  end

  // counters, direction latch and read handshake tracking
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      beat      <= '0;
      is_read   <= 1'b0;
      rd_wait   <= 1'b0;
      tx_done_q <= 1'b0;
    end else begin
      tx_done_q <= !abort && tx_last && last_beat;
      if (abort) begin
        cnt     <= '0;
        beat    <= '0;
        rd_wait <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: if (start) begin
            cnt     <= CNT_W'(1);
            beat    <= '0;
            is_read <= read_en;
            rd_wait <= 1'b0;
          end
          ST_RX_HDR:  if (accept) cnt <= hdr_last ? '0 : cnt + CNT_W'(1);
          ST_RX_DATA: if (accept) cnt <= data_last ? '0 : cnt + CNT_W'(1);
          ST_MEM_WR:  if (!last_beat) beat <= beat + BURST_WIDTH'(1);
          ST_MEM_RD: begin
            if (!rd_wait)        rd_wait <= 1'b1;
            else if (mem_rvalid) rd_wait <= 1'b0;
          end
          ST_TX_DATA: if (tx_xfer) begin
            cnt <= tx_last ? '0 : cnt + CNT_W'(1);
            if (tx_last && !last_beat) beat <= beat + BURST_WIDTH'(1);
          end
          default: ;
        endcase
      end
    end
  end

  // outputs; strobes are gated by slave_select so an abort cycle issues nothing
  always_comb begin
    busy          = (state != ST_IDLE);
    slave_ready   = (state == ST_IDLE) || (state == ST_RX_HDR) || (state == ST_RX_DATA);
    slave_valid   = (state == ST_TX_DATA);
    tx_data       = (state == ST_TX_DATA) && tx_bit;
    mem_write     = (state == ST_MEM_WR) && slave_select;
    mem_read      = (state == ST_MEM_RD) && !rd_wait && slave_select;
    rx_done       = (state == ST_MEM_WR) && slave_select && last_beat;
    slave_tx_done = tx_done_q;
    mem_address   = '0;
    mem_wdata     = '0;
    if (mem_write || mem_read) mem_address = addr_q + ADDR_WIDTH'(beat);
    if (mem_write)             mem_wdata   = wdata_q;
  end

endmodule

// File: tb/tb_slave_port.sv
// Directed + randomized bench for slave_port; the bench plays master and memory.
module tb_slave_port;

  localparam int AW = 12;
  localparam int DW = 8;
  localparam int BW = 13;
  localparam int HL = 13;

  logic          clk = 1'b0;
  logic          reset, slave_select, master_valid, write_en, read_en;
  logic          rx_address, rx_burst_number, rx_data, master_ready;
  logic          slave_ready, slave_valid, tx_data, slave_tx_done, rx_done, busy;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_write, mem_read, mem_rvalid;

  slave_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_WIDTH(BW)) dut (
    .clk(clk), .reset(reset), .slave_select(slave_select), .master_valid(master_valid),
    .write_en(write_en), .read_en(read_en), .rx_address(rx_address),
    .rx_burst_number(rx_burst_number), .rx_data(rx_data), .master_ready(master_ready),
    .slave_ready(slave_ready), .slave_valid(slave_valid), .tx_data(tx_data),
    .slave_tx_done(slave_tx_done), .rx_done(rx_done), .busy(busy),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_write(mem_write),
    .mem_read(mem_read), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errs = 0;
  int wr_cnt = 0, rxd_cnt = 0, txd_cnt = 0;
  logic [7:0] mem [0:4095];

  // event counters sampled mid-cycle
  always @(negedge clk) begin
    if (mem_write)     wr_cnt++;
    if (rx_done)       rxd_cnt++;
    if (slave_tx_done) txd_cnt++;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // present one serial bit after 'pre' idle cycles; hold it until accepted
  task automatic send_bit(input logic a, input logic b, input logic d, input int pre);
    logic ok;
    int guard;
    repeat (pre) begin master_valid = 1'b0; tick(); end
    master_valid = 1'b1; rx_address = a; rx_burst_number = b; rx_data = d;
    guard = 0;
    do begin ok = slave_ready; tick(); guard++; end while (!ok && guard < 50);
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    master_valid = 1'b0;
  endtask

  function automatic int rnd_pause(input bit rnd);
    if (!rnd) return 0;
    return ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
  endfunction

  task automatic send_header(input logic [AW-1:0] addr, input logic [BW-1:0] burst,
                             input bit rd, input int pause_pos, input int pause_len,
                             input bit rnd);
    logic [HL-1:0] a_ext;
    a_ext = {1'($urandom), addr};
    write_en = !rd; read_en = rd;
    for (int i = 0; i < HL; i++) begin
      send_bit(a_ext[i], burst[i], 1'($urandom),
               (i == pause_pos) ? pause_len : ((i > 0) ? rnd_pause(rnd) : 0));
      write_en = 1'b0; read_en = 1'b0;
    end
  endtask

  task automatic write_frame(input logic [AW-1:0] addr, input int burst,
                             input logic [7:0] d [8], input int pause_pos,
                             input int pause_len, input bit rnd);
    int w0, r0;
    logic [AW-1:0] ea;
    w0 = wr_cnt; r0 = rxd_cnt;
    send_header(addr, BW'(burst), 1'b0, pause_pos, pause_len, rnd);
    for (int b = 0; b <= burst; b++) begin
      for (int j = 0; j < DW; j++) send_bit(1'($urandom), 1'($urandom), d[b][j], rnd_pause(rnd));
      ea = addr + AW'(b);
      chk("wr_strobe", 32'(mem_write), 32'd1);
      chk("wr_addr", 32'(mem_address), 32'(ea));
      chk("wr_data", 32'(mem_wdata), 32'(d[b]));
      chk("wr_rx_done", 32'(rx_done), 32'(b == burst));
      chk("wr_ready_low", 32'(slave_ready), 32'd0);
      mem[ea] = d[b];
      tick();
    end
    chk("wr_busy_end", 32'(busy), 32'd0);
    chk("wr_count", 32'(wr_cnt - w0), 32'(burst + 1));
    chk("wr_done_count", 32'(rxd_cnt - r0), 32'd1);
  endtask

  task automatic read_frame(input logic [AW-1:0] addr, input int burst, input int lat,
                            input int stall_pos, input int stall_len, input bit rnd);
    int t0, st, l;
    logic [AW-1:0] ea;
    logic [7:0] exp;
    t0 = txd_cnt;
    send_header(addr, BW'(burst), 1'b1, -1, 0, rnd);
    for (int b = 0; b <= burst; b++) begin
      ea = addr + AW'(b);
      exp = mem[ea];
      chk("rd_strobe", 32'(mem_read), 32'd1);
      chk("rd_addr", 32'(mem_address), 32'(ea));
      l = rnd ? int'($urandom_range(1, 4)) : lat;
      tick();
      repeat (l - 1) begin
        chk("rd_wait_ready", 32'(slave_ready), 32'd0);
        tick();
      end
      mem_rvalid = 1'b1; mem_rdata = exp;
      tick();
      mem_rvalid = 1'b0; mem_rdata = 8'($urandom);
      for (int j = 0; j < DW; j++) begin
        st = (j == stall_pos) ? stall_len : (rnd ? int'($urandom_range(0, 2)) : 0);
        master_ready = 1'b0;
        repeat (st) begin
          chk("tx_hold_bit", 32'(tx_data), 32'(exp[j]));
          chk("tx_hold_valid", 32'(slave_valid), 32'd1);
          tick();
        end
        master_ready = 1'b1;
        chk("tx_bit", 32'(tx_data), 32'(exp[j]));
        tick();
        master_ready = 1'b0;
      end
    end
    chk("rd_tx_done", 32'(slave_tx_done), 32'd1);
    chk("rd_busy_end", 32'(busy), 32'd0);
    tick();
    chk("rd_tx_done_pulse", 32'(slave_tx_done), 32'd0);
    chk("rd_done_count", 32'(txd_cnt - t0), 32'd1);
  endtask

  initial begin
    logic [7:0] d [8];
    logic [AW-1:0] ra;
    int rb, w0, r0;

    reset = 1'b1; slave_select = 1'b0; master_valid = 1'b0; write_en = 1'b0;
    read_en = 1'b0; rx_address = 1'b0; rx_burst_number = 1'b0; rx_data = 1'b0;
    master_ready = 1'b0; mem_rdata = '0; mem_rvalid = 1'b0;
    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
    tick(); tick();
    chk("rst_ready", 32'(slave_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(slave_valid), 32'd0);
    chk("rst_strobes", {30'd0, mem_write, mem_read}, 32'd0);
    reset = 1'b0; slave_select = 1'b1;
    tick();

    // single write
    d[0] = 8'hFF;
    write_frame(12'hADD, 0, d, -1, 0, 1'b0);

    // burst write across the address wrap
    d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33;
    write_frame(12'hFFF, 2, d, -1, 0, 1'b0);

    // read with memory latency 3 and a 2-cycle stall mid-byte
    mem[12'h010] = 8'hA5;
    read_frame(12'h010, 0, 3, 4, 2, 1'b0);

    // header pause of 4 cycles
    d[0] = 8'hFF;
    write_frame(12'hADD, 0, d, 6, 4, 1'b0);

    // illegal starts: both enables, then neither
    master_valid = 1'b1; write_en = 1'b1; read_en = 1'b1; tick();
    chk("illegal_both", 32'(busy), 32'd0);
    write_en = 1'b0; read_en = 1'b0; tick();
    chk("illegal_none", 32'(busy), 32'd0);
    master_valid = 1'b0;

    // abort after 5 data bits
    w0 = wr_cnt; r0 = rxd_cnt;
    send_header(12'h123, 13'd0, 1'b0, -1, 0, 1'b0);
    for (int j = 0; j < 5; j++) send_bit(1'b0, 1'b0, 1'b1, 0);
    slave_select = 1'b0; tick();
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_ready", 32'(slave_ready), 32'd1);
    slave_select = 1'b1; tick();
    chk("abort_no_write", 32'(wr_cnt - w0), 32'd0);
    chk("abort_no_done", 32'(rxd_cnt - r0), 32'd0);
    d[0] = 8'h5A;
    write_frame(12'h456, 0, d, -1, 0, 1'b0);

    // abort colliding with the last-beat strobe
    w0 = wr_cnt; r0 = rxd_cnt;
    send_header(12'h321, 13'd0, 1'b0, -1, 0, 1'b0);
    for (int j = 0; j < DW; j++) send_bit(1'b0, 1'b0, 1'b1, 0);
    slave_select = 1'b0; #1;
    chk("abort_wr_strobe", 32'(mem_write), 32'd0);
    chk("abort_wr_done", 32'(rx_done), 32'd0);
    tick();
    chk("abort_wr_busy", 32'(busy), 32'd0);
    slave_select = 1'b1; tick();
    chk("abort_wr_count", 32'(wr_cnt - w0 + rxd_cnt - r0), 32'd0);

    // reset while serialising read data
    send_header(12'h020, 13'd0, 1'b1, -1, 0, 1'b0);
    tick();
    mem_rvalid = 1'b1; mem_rdata = 8'hC3; tick();
    mem_rvalid = 1'b0; master_ready = 1'b1; tick();
    chk("pre_rst_valid", 32'(slave_valid), 32'd1);
    reset = 1'b1; tick();
    chk("midrst_ready", 32'(slave_ready), 32'd1);
    chk("midrst_outs", {25'd0, busy, slave_valid, tx_data, slave_tx_done, rx_done,
                        mem_write, mem_read}, 32'd0);
    chk("midrst_addr", 32'(mem_address), 32'd0);
    reset = 1'b0; master_ready = 1'b0; tick();

    // randomized mix of writes and reads with pauses, stalls and latencies
    for (int n = 0; n < 24; n++) begin
      ra = AW'($urandom);
      rb = int'($urandom_range(0, 3));
      for (int b = 0; b < 8; b++) d[b] = 8'($urandom);
      if ($urandom_range(0, 1) == 0) write_frame(ra, rb, d, -1, 0, 1'b1);
      else                           read_frame(ra, rb, 1, -1, 0, 1'b1);
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
